// File: rtl/result_writer.sv
// result_writer: delays the fetch enable by LATENCY and writes DEPTH products to result BRAM port B.
// Optional RESULT_CHECKSUM_EN adds csum, the running sum of every product written this run.
module result_writer #(
    parameter int OPW     = 16,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              start_stop,
    input  logic              src_en,
    input  logic [2*OPW-1:0]  p,
    output logic [ADDR_W-1:0] addrb,
    output logic              enb,
    output logic              web,
    output logic [2*OPW-1:0]  dinb,
    output logic [ADDR_W:0]   wr_count,
    output logic              done
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [2*OPW-1:0]  csum
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              state;
    logic [LATENCY-1:0]  sr;
    logic [ADDR_W-1:0]   ptr;
    logic                ss_prev;
    logic                stb;
    logic                last;
    assign stb  = sr[LATENCY-1];
    assign last = wr_count == (ADDR_W+1)'(DEPTH - 1);
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= '0;
            ptr      <= '0;
            ss_prev  <= 1'b0;
            addrb    <= '0;
            enb      <= 1'b0;
            web      <= 1'b0;
            dinb     <= '0;
            wr_count <= '0;
            done     <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            ss_prev <= start_stop;
            enb     <= 1'b0;
            web     <= 1'b0;
            case (state)
                IDLE: begin
                    sr <= '0;
                    if (start_stop && !ss_prev) begin
                        state    <= RUN;
                        ptr      <= '0;
                        wr_count <= '0;
`ifdef RESULT_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                RUN: begin
                    sr <= LATENCY'({sr, src_en});
                    if (stb) begin
                        addrb    <= ptr;
                        dinb     <= p;
                        enb      <= 1'b1;
                        web      <= 1'b1;
                        ptr      <= ptr + 1'b1;
                        wr_count <= wr_count + 1'b1;
`ifdef RESULT_CHECKSUM_EN
                        csum     <= csum + p;
`endif
                    end
                    // an abort still lets this cycle's write through, but never enters DONE
                    if (!start_stop)
                        state <= IDLE;
                    else if (stb && last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    sr <= LATENCY'({sr, src_en});
                    if (!start_stop) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: scoreboard bench for result_writer (LATENCY=2, DEPTH=16).
module tb_result_writer;
    localparam int DEPTH = 16;
    logic        clka = 1'b0, reset = 1'b1, start_stop = 1'b0, src_en = 1'b0;
    logic [31:0] p = '0;
    logic [3:0]  addrb;
    logic        enb, web, done;
    logic [31:0] dinb;
    logic [4:0]  wr_count;
`ifdef RESULT_CHECKSUM_EN
    logic [31:0] csum;
`endif
    result_writer #(.OPW(16), .ADDR_W(4), .DEPTH(DEPTH), .LATENCY(2)) dut (
        .clka(clka), .reset(reset), .start_stop(start_stop), .src_en(src_en), .p(p),
        .addrb(addrb), .enb(enb), .web(web), .dinb(dinb), .wr_count(wr_count), .done(done)
`ifdef RESULT_CHECKSUM_EN
        , .csum(csum)
`endif
    );
    always #5 clka = ~clka;
    typedef struct {int c; int a; logic [31:0] d;} exp_t;
    exp_t sb[$];
    int total = 0, bad = 0, cyc = 0, nexp = 0, dcnt = 1;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(posedge clka) cyc++;
    always @(negedge clka) begin
        if (enb) begin
            if (sb.size() == 0) check("unexpected_enb", enb, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_cycle", cyc, e.c);
                check("wr_addr", addrb, e.a);
                check("wr_data", dinb, e.d);
                check("wr_web", web, 1);
            end
        end
    end
    task automatic tick;
        @(posedge clka);
        #1;
    endtask
    task automatic begin_run;
        start_stop = 1'b0;
        tick;
        start_stop = 1'b1;
        tick;
        nexp = 0;
        dcnt = 1;
    endtask
    // products arrive two cycles after their fetch enable; writes land one cycle later
    task automatic drive(input logic [31:0] pat, input int len);
        logic [31:0] pd [0:63];
        for (int k = 0; k < len + 4; k++) begin
            src_en = (k < len) ? pat[k] : 1'b0;
            if (k >= 2 && k - 2 < len && pat[k-2]) p = pd[k-2];
            else p = 32'hDEAD_0000 + k;
            if (src_en) begin
                pd[k] = dcnt;
                if (nexp < DEPTH) sb.push_back('{cyc + 3, nexp, dcnt});
                nexp++;
                dcnt++;
            end
            tick;
        end
        src_en = 1'b0;
    endtask
    initial begin
        tick;
        tick;
        check("rst_addrb", addrb, 0);
        check("rst_enb", enb, 0);
        check("rst_web", web, 0);
        check("rst_dinb", dinb, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick;
        begin_run;
        drive(32'h0000_FFFF, 16);
        check("full_done", done, 1);
        check("full_wr_count", wr_count, 16);
        check("full_sb_empty", sb.size(), 0);
`ifdef RESULT_CHECKSUM_EN
        check("full_csum", csum, 32'h0000_0088);
`endif
        begin_run;
        check("restart_done_clear", done, 0);
        drive(32'h000F_FFFF, 20);
        check("over_wr_count", wr_count, 16);
        check("over_done", done, 1);
        check("over_sb_empty", sb.size(), 0);
        begin_run;
        drive(32'h0000_000D, 5);
        check("gap_wr_count", wr_count, 3);
        check("gap_done", done, 0);
        check("gap_sb_empty", sb.size(), 0);
        begin_run;
        drive(32'h0000_007F, 7);
        start_stop = 1'b0;
        tick;
        tick;
        check("abort_wr_count", wr_count, 7);
        check("abort_done", done, 0);
        begin_run;
        drive(32'h0000_0003, 2);
        check("restart_wr_count", wr_count, 2);
        check("restart_sb_empty", sb.size(), 0);
        begin_run;
        drive(32'h0000_001F, 5);
        check("mid_wr_count", wr_count, 5);
        reset = 1'b1;
        #1;
        check("mid_rst_addrb", addrb, 0);
        check("mid_rst_dinb", dinb, 0);
        check("mid_rst_wr_count", wr_count, 0);
        check("mid_rst_enb", enb, 0);
        check("mid_rst_done", done, 0);
        start_stop = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        check("post_rst_addrb", addrb, 0);
        check("post_rst_enb", enb, 0);
        src_en = 1'b1;
        repeat (5) tick;
        src_en = 1'b0;
        tick;
        check("post_rst_idle_wr_count", wr_count, 0);
        check("post_rst_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
